// File: rtl/eth_pcs_tx_gearbox.sv
// rtl/eth_pcs_tx_gearbox.sv - 64b/66b TX gearbox, 66-bit blocks onto a continuous 32-bit PMA word
module eth_pcs_tx_gearbox #(
  parameter int W_DATA         = 32,
  parameter int W_SYNC         = 2,
  parameter int TX_GEARBOX_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_hdr_valid,
  input  logic [W_SYNC-1:0] i_hdr,
  input  logic              i_data_valid,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_grbx_ready,
  output logic [W_DATA-1:0] o_pma_data,
  output logic              o_err
);

  localparam int W_RES = W_DATA + W_SYNC;
  localparam int W_CAT = W_DATA + W_RES;
  localparam int W_SEQ = $clog2(TX_GEARBOX_CNT + 1);
  localparam int W_CNT = $clog2(W_RES + 1);

  logic [W_SEQ-1:0]  q_seq;
  logic [W_CNT-1:0]  q_cnt;
  logic [W_RES-1:0]  q_res;

  logic              stall;
  logic              hdr_cycle;
  logic              err;
  logic [W_SYNC-1:0] hdr_word;
  logic [W_DATA-1:0] data_word;
  logic [W_RES-1:0]  new_bits;
  logic [W_RES-1:0]  res_masked;
  logic [W_CAT-1:0]  cat;

  assign stall        = (q_seq == W_SEQ'(TX_GEARBOX_CNT));
  assign hdr_cycle    = ~q_seq[0] & ~stall;
  assign o_grbx_ready = ~stall & ~i_reset;

  always_comb begin
    hdr_word   = i_hdr_valid  ? i_hdr  : '0;
    data_word  = i_data_valid ? i_data : '0;
    new_bits   = '0;
    res_masked = '0;
    cat        = '0;
    err        = 1'b0;

    if (hdr_cycle) new_bits = {data_word, hdr_word};
    else           new_bits = {{W_SYNC{1'b0}}, data_word};

    for (int i = 0; i < W_RES; i++)
      res_masked[i] = (W_CNT'(i) < q_cnt) ? q_res[i] : 1'b0;

    // Residual is older, so new bits land just above it; q_cnt is always even.
    for (int s = 0; s <= W_DATA; s += W_SYNC)
      if (q_cnt == W_CNT'(s)) cat = {{W_DATA{1'b0}}, new_bits} << s;
    cat = cat | {{W_DATA{1'b0}}, res_masked};

    if (stall)          err = i_hdr_valid | i_data_valid;
    else if (hdr_cycle) err = ~i_hdr_valid | ~i_data_valid;
    else                err = i_hdr_valid | ~i_data_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q_seq      <= '0;
      q_cnt      <= '0;
      q_res      <= '0;
      o_pma_data <= '0;
      o_err      <= 1'b0;
    end else begin
      q_seq <= stall ? '0 : q_seq + W_SEQ'(1);
      o_err <= err;
      if (stall) begin
        o_pma_data <= q_res[W_DATA-1:0];
        q_res      <= '0;
        q_cnt      <= '0;
      end else begin
        o_pma_data <= cat[W_DATA-1:0];
        q_res      <= cat[W_CAT-1:W_DATA];
        if (hdr_cycle) q_cnt <= q_cnt + W_CNT'(W_SYNC);
      end
    end
  end

endmodule
